rc_pwm_decoder: RTL and testbench

// - Receive side of the servo-style PWM link: measures the high time of an incoming RC pulse

---
 rtl/rc_pwm_decoder.sv | 188 ++++++++++++++++++
 tb/tb_rc_pwm_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rc_pwm_decoder.sv
// RC servo pulse-width decoder: measures high time in us and maps it to a 3-bit drive code (CMD_FILTER_EN adds a two-pulse cmd filter).
// Latency: pwm_in fall to pulse_valid/pulse_err is 4 CLK_50M cycles; no backpressure, strobes are single-cycle and unbuffered.
module rc_pwm_decoder #(
  parameter int CLK_DIV      = 50,
  parameter int W            = 12,
  parameter int MIN_US       = 900,
  parameter int MAX_US       = 2100,
  parameter int BAND_BASE_US = 1000,
  parameter int BAND_US      = 200,
  parameter int TIMEOUT_US   = 25000
) (
  input  logic         CLK_50M,
  input  logic         Reset,
  input  logic         pwm_in,
  output logic [W-1:0] width_us,
  output logic [2:0]   cmd,
  output logic         pulse_valid,
  output logic         pulse_err,
  output logic         link_ok
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_US + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_US - 1);
  localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT_US);
  localparam logic [W-1:0]  MIN_W    = W'(MIN_US);
  localparam logic [W-1:0]  MAX_W    = W'(MAX_US);
  localparam logic [W-1:0]  OVF_W    = W'(MAX_US + 1);
  localparam logic [W-1:0]  EDGE1    = W'(BAND_BASE_US + BAND_US);
  localparam logic [W-1:0]  EDGE2    = W'(BAND_BASE_US + 2 * BAND_US);
  localparam logic [W-1:0]  EDGE3    = W'(BAND_BASE_US + 3 * BAND_US);
  localparam logic [W-1:0]  EDGE4    = W'(BAND_BASE_US + 4 * BAND_US);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    pwm_sync;
  logic          rise, fall;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic [W-1:0]  high_cnt, hc_nxt;
  logic          accept, reject;
  logic [2:0]    cmd_new;
  logic          cmd_take;

  // Sync chain resets high so a pulse already in progress at reset release never looks like a rise.
  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      pwm_sync <= '1;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      pwm_sync <= {pwm_sync[1:0], pwm_in};
      rise     <= pwm_sync[1] & ~pwm_sync[2];
      fall     <= ~pwm_sync[1] & pwm_sync[2];
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      pre_cnt <= '0;
    end else if (rise || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      to_cnt <= '0;
    end else if (rise) begin
      to_cnt <= '0;
    end else if (tick && (to_cnt != TO_SAT)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = tick && !rise && (to_cnt == TO_LAST);

  // Include the tick landing on the fall cycle so the count is exact for whole-us pulses.
  assign hc_nxt = high_cnt + {{(W-1){1'b0}}, tick};

  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      state    <= WAIT_LOW;
      high_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT_RISE && rise) begin
        high_cnt <= '0;
      end else if (state == MEASURE) begin
        high_cnt <= hc_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (!pwm_sync[2]) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (fall) begin
          if (hc_nxt >= MIN_W && hc_nxt <= MAX_W) accept = 1'b1;
          else                                    reject = 1'b1;
          state_nxt = WAIT_RISE;
        end else if (hc_nxt == OVF_W) begin
          reject    = 1'b1;
          state_nxt = WAIT_LOW;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  function automatic logic [2:0] band(input logic [W-1:0] w);
    if (w < EDGE1)      band = 3'b000;
    else if (w < EDGE2) band = 3'b001;
    else if (w < EDGE3) band = 3'b010;
    else if (w < EDGE4) band = 3'b011;
    else                band = 3'b100;
  endfunction

  assign cmd_new = band(hc_nxt);

`ifdef CMD_FILTER_EN
  logic [2:0] cand;
  logic       cand_vld;

  assign cmd_take = accept && cand_vld && (cand == cmd_new);

  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      cand     <= 3'b000;
      cand_vld <= 1'b0;
    end else if (accept) begin
      cand     <= cmd_new;
      cand_vld <= 1'b1;
    end else if (reject || to_hit) begin
      cand_vld <= 1'b0;
    end
  end
`else
  assign cmd_take = accept;
`endif

  always_ff @(posedge CLK_50M or negedge Reset) begin
    if (!Reset) begin
      width_us    <= '0;
      cmd         <= 3'b000;
      pulse_valid <= 1'b0;
      pulse_err   <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      pulse_valid <= accept;
      pulse_err   <= reject;
      // An accept in the timeout cycle takes priority over dropping the link.
      if (accept) begin
        width_us <= hc_nxt;
        if (cmd_take) begin
          cmd     <= cmd_new;
          link_ok <= 1'b1;
        end
      end else if (to_hit) begin
        cmd     <= 3'b000;
        link_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// Bench for rc_pwm_decoder with a time-scaled configuration (2 clocks/us, 90..210 us window, 2500 us timeout).
module tb_rc_pwm_decoder;

  localparam int D    = 2;
  localparam int W    = 12;
  localparam int MINU = 90;
  localparam int MAXU = 210;
  localparam int BASE = 100;
  localparam int BAND = 20;
  localparam int TO   = 2500;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwm   = 1'b0;
  logic [W-1:0] width_us;
  logic [2:0]   cmd;
  logic         pulse_valid;
  logic         pulse_err;
  logic         link_ok;

  rc_pwm_decoder #(
    .CLK_DIV(D), .W(W), .MIN_US(MINU), .MAX_US(MAXU),
    .BAND_BASE_US(BASE), .BAND_US(BAND), .TIMEOUT_US(TO)
  ) dut (
    .CLK_50M(clk),
    .Reset(rst_n),
    .pwm_in(pwm),
    .width_us(width_us),
    .cmd(cmd),
    .pulse_valid(pulse_valid),
    .pulse_err(pulse_err),
    .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Strobe monitor: running totals, sampled on the falling edge.
  int v_cnt = 0;
  int e_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (pulse_valid) v_cnt++;
    if (pulse_err) e_cnt++;
    if (pulse_valid && pulse_err) both_cnt++;
  end

  // Reference model: what the link should report after each whole pulse.
  int m_width = 0;
  int m_cmd   = 0;
  int m_link  = 0;
  int m_cand  = -1;

  function automatic int ref_band(input int h);
    int b;
    if (h < BASE) return 0;
    b = (h - BASE) / BAND;
    return (b > 4) ? 4 : b;
  endfunction

  task automatic model_pulse(input int h, output int want_v, output int want_e);
    if (h < MINU || h > MAXU) begin
      want_v = 0;
      want_e = 1;
      m_cand = -1;
    end else begin
      want_v  = 1;
      want_e  = 0;
      m_width = h;
`ifdef CMD_FILTER_EN
      if (m_cand == ref_band(h)) begin
        m_cmd  = ref_band(h);
        m_link = 1;
      end
      m_cand = ref_band(h);
`else
      m_cmd  = ref_band(h);
      m_link = 1;
`endif
    end
  endtask

  task automatic model_reset();
    m_width = 0;
    m_cmd   = 0;
    m_link  = 0;
    m_cand  = -1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_width(input string tag);
    int dev;
    dev = int'(width_us) - m_width;
    if (dev < 0) dev = -dev;
    if (dev <= 1) dev = 0;
    chk(tag, dev, 0);
  endtask

  task automatic send(input int h, input int gap);
    int v0, e0, wv, we;
    v0 = v_cnt;
    e0 = e_cnt;
    pwm = 1'b1;
    cyc(h * D);
    pwm = 1'b0;
    cyc(5);
    model_pulse(h, wv, we);
    chk("n_valid", v_cnt - v0, wv);
    chk("n_err", e_cnt - e0, we);
    chk("cmd", int'(cmd), m_cmd);
    chk_width("width_dev");
    chk("link_ok", int'(link_ok), m_link);
    cyc(gap * D);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_width"}, int'(width_us), 0);
    chk({tag, "_cmd"}, int'(cmd), 0);
    chk({tag, "_link"}, int'(link_ok), 0);
    chk({tag, "_valid"}, int'(pulse_valid), 0);
    chk({tag, "_err"}, int'(pulse_err), 0);
  endtask

  initial begin
    int dir[$];
    int v0, e0, wv, we, h, gap;

    cyc(4);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(20);

    // Nominal frames, band sweep, band edge, short/long rejects, filter sequence.
    dir = '{150, 150, 150, 100, 125, 145, 170, 195, 119, 120, 50, 250, 150, 180, 180};
    foreach (dir[i]) send(dir[i], 100);

    // Link loss: one valid pulse, then input held low past the timeout.
    v0 = v_cnt;
    pwm = 1'b1;
    cyc(150 * D);
    pwm = 1'b0;
    model_pulse(150, wv, we);
    cyc((TO - 10 - 150) * D);
    chk("to_valid", v_cnt - v0, wv);
    chk("to_link_before", int'(link_ok), m_link);
    chk("to_cmd_before", int'(cmd), m_cmd);
    cyc(20 * D);
    m_link = 0;
    m_cmd  = 0;
    m_cand = -1;
    chk("to_link_after", int'(link_ok), 0);
    chk("to_cmd_after", int'(cmd), 0);
    chk_width("to_width_held");
    cyc(500 * D);

    // Random pulse stream, gaps kept well inside the timeout.
    repeat (40) begin
      h   = $urandom_range(240, 70);
      gap = $urandom_range(300, 20);
      send(h, gap);
    end

    // Reset in the middle of a high pulse: that pulse must be ignored.
    pwm = 1'b1;
    cyc(50 * D);
    rst_n = 1'b0;
    cyc(2);
    chk_zero("midrst");
    model_reset();
    rst_n = 1'b1;
    v0 = v_cnt;
    e0 = e_cnt;
    cyc(60 * D);
    pwm = 1'b0;
    cyc(50 * D);
    chk("midrst_no_valid", v_cnt - v0, 0);
    chk("midrst_no_err", e_cnt - e0, 0);
    send(150, 100);
    send(150, 100);

    chk("strobe_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
